uncache_store_buffer: RTL

- Sits between the memory stage and the AXI bridge's uncache port.
- Posts uncached stores into a small FIFO so the pipeline does not stall on MMIO writes.
- Drains the FIFO one request at a time through the bridge's level/refresh handshake.
- Issues uncached loads only after every older store has completed, which keeps strict program order to device space.

---
 rtl/uncache_store_buffer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/uncache_store_buffer.sv
// Uncached access buffer between the memory stage and the bridge's uncache port.
// Stores are posted into a FIFO; loads wait until every older store has completed.
module uncache_store_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cpu_en,
    input  logic [3:0]  cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rvalid,
    output logic        uncache_en,
    output logic [3:0]  uncache_wen,
    output logic [31:0] uncache_addr,
    output logic [31:0] uncache_wdata,
    input  logic [31:0] uncache_rdata,
    input  logic        uncache_refresh
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD
    } state_e;

    state_e             state_q, state_d;
    req_t               fifo_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               en_q, en_d;
    req_t               req_q, req_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;

    logic is_store, is_load, full, empty, push, pop, load_start;

    assign is_store   = cpu_en & (|cpu_wen);
    assign is_load    = cpu_en & ~(|cpu_wen);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == CNT_W'(0));
    assign push       = is_store & ~full;
    assign load_start = is_load & empty & ~rvalid_q & ~push;

    // Stall until a store finds room or a load sees its completion pulse.
    assign cpu_stall  = cpu_en & ~(is_store & ~full) & ~(is_load & rvalid_q);

    assign cpu_rdata     = rdata_q;
    assign cpu_rvalid    = rvalid_q;
    assign uncache_en    = en_q;
    assign uncache_wen   = req_q.wen;
    assign uncache_addr  = req_q.addr;
    assign uncache_wdata = req_q.wdata;

    // Entry storage carries no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{wen: cpu_wen, addr: cpu_addr, wdata: cpu_wdata};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            en_q     <= 1'b0;
            req_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            req_q    <= req_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Every transaction returns through IDLE, so uncache_en drops for a cycle after refresh.
    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        req_d    = req_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        pop      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    state_d = S_WR;
                    en_d    = 1'b1;
                    req_d   = fifo_q[rd_ptr_q];
                end else if (load_start) begin
                    state_d = S_RD;
                    en_d    = 1'b1;
                    req_d   = '{wen: 4'b0000, addr: cpu_addr, wdata: 32'h0};
                end
            end
            S_WR: begin
                if (uncache_refresh) begin
                    pop     = 1'b1;
                    en_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                if (uncache_refresh) begin
                    rdata_d  = uncache_rdata;
                    rvalid_d = 1'b1;
                    en_d     = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                en_d    = 1'b0;
            end
        endcase
    end

endmodule
